// File: rtl/piradip_axis_ram_stream_reader.sv
// piradip_axis_ram_stream_reader
// Playback engine for the stream side of a sample buffer. Walks a synchronous-read RAM port
// from a start offset to an end offset (looping or one-shot), tracks the reads still in flight
// through the RAM pipeline and lands the returned words in a first-word-fall-through FIFO
// that feeds an AXI4-Stream manager. Reads are only issued while the FIFO plus in-flight
// reads leave PROG_FULL_THRESH slots in reserve, so the FIFO can never overflow.

module piradip_axis_ram_stream_reader #(
    parameter int DATA_WIDTH       = 256,
    parameter int ADDR_WIDTH       = 10,
    parameter int READ_LATENCY     = 1,
    parameter int FIFO_DEPTH       = 16,
    parameter int PROG_FULL_THRESH = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cfg_update,
    input  logic                  cfg_active,
    input  logic                  cfg_one_shot,
    input  logic [ADDR_WIDTH-1:0] cfg_start_offset,
    input  logic [ADDR_WIDTH-1:0] cfg_end_offset,
    output logic                  running,
    output logic                  stopped,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
    localparam logic [CW-1:0] SPACE_LIMIT = CW'(FIFO_DEPTH - PROG_FULL_THRESH);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    stopped_q;
    logic [READ_LATENCY-1:0] pipe_q;

    logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    logic [CW-1:0]           inflight;
    logic                    space;
    logic                    push;
    logic                    pop;

    assign running  = (state_q == ST_RUN);
    assign stopped  = stopped_q;
    assign mem_addr = addr_q;
    assign mem_en   = running & space;

    assign m_tvalid = (count_q != '0);
    assign m_tdata  = m_tvalid ? fifo_mem_q[rd_ptr_q] : '0;

    // Returned words land in the FIFO unless an update is flushing everything this cycle.
    assign push = pipe_q[READ_LATENCY-1] & ~cfg_update;
    assign pop  = m_tvalid & m_tready;

    // Count reads issued to the RAM whose data has not yet been written into the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_q[i]);
        end
    end

    // Only issue another read while FIFO plus in-flight reads stay below the reserve line.
    always_comb begin
        space = ((count_q + inflight) < SPACE_LIMIT);
    end

    // Read engine: configuration updates win, otherwise step the address on every issued read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            stopped_q <= 1'b0;
        end else begin
            stopped_q <= 1'b0;
            if (cfg_update) begin
                if (cfg_active) begin
                    state_q <= ST_RUN;
                    addr_q  <= cfg_start_offset;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else if (mem_en) begin
                if (addr_q >= cfg_end_offset) begin
                    addr_q <= cfg_start_offset;
                    if (cfg_one_shot) begin
                        state_q   <= ST_IDLE;
                        stopped_q <= 1'b1;
                    end
                end else begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Shift register marking which RAM pipeline stages carry a real read; cleared on update.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pipe_q <= '0;
        end else if (cfg_update) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= mem_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Next FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO bookkeeping registers; an update empties the FIFO in one cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (cfg_update) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage needs no reset: the occupancy count decides what is visible.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_piradip_axis_ram_stream_reader.sv
// Testbench for piradip_axis_ram_stream_reader
// Directed playback scenarios against an address-sequence model of the output stream.

module tb_piradip_axis_ram_stream_reader;

   localparam int DW   = 256;
   localparam int AW   = 10;
   localparam int RL   = 1;
   localparam int FD   = 16;
   localparam int PT   = 5;
   localparam int HOLD = FD - PT;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          cfg_update = 1'b0;
   logic          cfg_active = 1'b0;
   logic          cfg_one_shot = 1'b0;
   logic [AW-1:0] cfg_start_offset = '0;
   logic [AW-1:0] cfg_end_offset = '0;
   logic          running;
   logic          stopped;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic [DW-1:0] m_tdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic          mdlRun = 1'b0;
   logic          mdlOneShot = 1'b0;
   logic [AW-1:0] mdlStart = '0;
   logic [AW-1:0] mdlEnd = '0;
   logic [AW-1:0] issNext = '0;
   logic [AW-1:0] popNext = '0;
   int            issued = 0;
   int            popped = 0;
   int            held = 0;
   bit            expStop = 1'b0;
   bit            prevStall = 1'b0;
   logic [DW-1:0] prevData = '0;
   logic [AW-1:0] popLog[$];
   int            stopSeen = 0;
   bit            waitValid = 1'b0;
   bit            waitIssue = 1'b0;
   int            updCyc = 0;
   int            firstValidCyc = -100;
   int            firstIssueCyc = -100;
   logic [AW-1:0] firstWord = '0;

   piradip_axis_ram_stream_reader #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .READ_LATENCY(RL),
      .FIFO_DEPTH(FD),
      .PROG_FULL_THRESH(PT)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .cfg_update(cfg_update),
      .cfg_active(cfg_active),
      .cfg_one_shot(cfg_one_shot),
      .cfg_start_offset(cfg_start_offset),
      .cfg_end_offset(cfg_end_offset),
      .running(running),
      .stopped(stopped),
      .mem_en(mem_en),
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata),
      .m_tvalid(m_tvalid),
      .m_tready(m_tready),
      .m_tdata(m_tdata)
   );

   // Free-running clock and a cycle counter used to measure latencies.
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Word stored at each RAM address: the address repeated with a marker so corruption shows.
   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return {16{{6'h2A, a}}};
   endfunction

   // Address following a in the configured playback window.
   function automatic logic [AW-1:0] advance(input logic [AW-1:0] a);
      return (a >= mdlEnd) ? mdlStart : a + 10'd1;
   endfunction

   // Synchronous-read RAM with one cycle of latency.
   always @(posedge clk_in) begin
      if (mem_en) mem_rdata <= word(mem_addr);
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Compare the DUT every cycle against the expected issue/output address sequences.
   always @(negedge clk_in) begin
      if (rst_in) begin
         checkOutput("rst_tvalid", m_tvalid, 1'b0);
         checkOutput("rst_running", running, 1'b0);
         checkOutput("rst_mem_en", mem_en, 1'b0);
         checkOutput("rst_stopped", stopped, 1'b0);
         mdlRun = 1'b0;
         issued = 0;
         popped = 0;
         held = 0;
         expStop = 1'b0;
         prevStall = 1'b0;
      end else begin
         checkOutput("running", running, mdlRun);
         checkOutput("stopped", stopped, expStop);
         if (stopped) stopSeen++;
         expStop = 1'b0;
         if (mem_en) begin
            checkOutput("mem_en_idle", mem_en, mdlRun);
            checkOutput("mem_addr", mem_addr, issNext);
            if (waitIssue) begin
               firstIssueCyc = cyc;
               waitIssue = 1'b0;
            end
            if (mdlRun) begin
               if (issNext >= mdlEnd && mdlOneShot) begin
                  expStop = 1'b1;
                  mdlRun = 1'b0;
               end
               issNext = advance(issNext);
               issued++;
            end
         end
         if (prevStall) begin
            checkOutput("hold_valid", m_tvalid, 1'b1);
            checkOutput("hold_data", m_tdata, prevData);
         end
         if (m_tvalid) begin
            if (waitValid) begin
               firstValidCyc = cyc;
               firstWord = m_tdata[AW-1:0];
               waitValid = 1'b0;
            end
            checkOutput("tvalid_unbacked", issued > popped, 1'b1);
            if (m_tready) begin
               checkOutput("tdata", m_tdata, word(popNext));
               popLog.push_back(m_tdata[AW-1:0]);
               popNext = advance(popNext);
               popped++;
            end
         end
         held = issued - popped;
         checkOutput("held_limit", held <= HOLD, 1'b1);
         prevStall = m_tvalid && !m_tready;
         prevData = m_tdata;
         if (cfg_update) begin
            expStop = 1'b0;
            issued = 0;
            popped = 0;
            prevStall = 1'b0;
            if (cfg_active) begin
               mdlRun = 1'b1;
               mdlOneShot = cfg_one_shot;
               mdlStart = cfg_start_offset;
               mdlEnd = cfg_end_offset;
               issNext = cfg_start_offset;
               popNext = cfg_start_offset;
               waitValid = 1'b1;
               waitIssue = 1'b1;
               firstValidCyc = -100;
               firstIssueCyc = -100;
               updCyc = cyc;
            end else begin
               mdlRun = 1'b0;
            end
         end
      end
   end

   // One-cycle configuration pulse; the offsets stay applied afterwards.
   task automatic applyStimulus(input logic active, input logic oneShot,
                                input logic [AW-1:0] startOff, input logic [AW-1:0] endOff);
      @(posedge clk_in);
      #1;
      cfg_active = active;
      cfg_one_shot = oneShot;
      cfg_start_offset = startOff;
      cfg_end_offset = endOff;
      cfg_update = 1'b1;
      @(posedge clk_in);
      #1;
      cfg_update = 1'b0;
   endtask

   task automatic waitPops(input int n, input int budget);
      for (int i = 0; i < budget && popLog.size() < n; i++) @(posedge clk_in);
      checkOutput("wait_pops", popLog.size() >= n, 1'b1);
   endtask

   // Logged words base..base+n-1 must read startOff + (i % period).
   task automatic checkLoopSeq(input string name, input int base, input int n,
                               input int startOff, input int period);
      if (popLog.size() < base + n) begin
         checkOutput({name, "_len"}, popLog.size(), base + n);
         return;
      end
      for (int i = 0; i < n; i++) begin
         checkOutput(name, popLog[base + i], startOff + (i % period));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int n;
      int mx;
      int stopBase;

      repeat (3) @(posedge clk_in);
      #1;
      checkOutput("reset_tvalid", m_tvalid, 1'b0);
      checkOutput("reset_tdata", m_tdata, '0);
      checkOutput("reset_mem_addr", mem_addr, '0);
      checkOutput("reset_running", running, 1'b0);
      rst_in = 1'b0;
      repeat (3) @(posedge clk_in);

      $display("[TB] loop 4..7");
      stopBase = stopSeen;
      applyStimulus(1'b1, 1'b0, 10'd4, 10'd7);
      base = popLog.size();
      waitPops(base + 10, 50);
      checkLoopSeq("loop_seq", base, 10, 4, 4);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_in);
         #1;
         if (m_tvalid) n++;
      end
      checkOutput("loop_gapless", n, 20);
      checkOutput("loop_no_stop", stopSeen - stopBase, 0);

      $display("[TB] one-shot 2..5");
      applyStimulus(1'b1, 1'b1, 10'd2, 10'd5);
      base = popLog.size();
      stopBase = stopSeen;
      repeat (30) @(posedge clk_in);
      #1;
      checkOutput("oneshot_count", popLog.size() - base, 4);
      checkLoopSeq("oneshot_seq", base, 4, 2, 4);
      checkOutput("oneshot_stopped", stopSeen - stopBase, 1);
      checkOutput("oneshot_running", running, 1'b0);

      $display("[TB] backpressure");
      m_tready = 1'b0;
      applyStimulus(1'b1, 1'b0, 10'd10, 10'd30);
      base = popLog.size();
      mx = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_in);
         #1;
         if (held > mx) mx = held;
      end
      checkOutput("bp_max_held", mx, HOLD);
      checkOutput("bp_no_pop", popLog.size() - base, 0);
      checkOutput("bp_tvalid", m_tvalid, 1'b1);
      m_tready = 1'b1;
      waitPops(base + 30, 80);
      checkLoopSeq("bp_seq", base, 30, 10, 21);

      $display("[TB] start==end and end<start");
      applyStimulus(1'b1, 1'b0, 10'd9, 10'd9);
      base = popLog.size();
      waitPops(base + 4, 30);
      checkLoopSeq("single_loop", base, 4, 9, 1);
      applyStimulus(1'b1, 1'b1, 10'd8, 10'd3);
      base = popLog.size();
      stopBase = stopSeen;
      repeat (20) @(posedge clk_in);
      #1;
      checkOutput("rev_count", popLog.size() - base, 1);
      checkLoopSeq("rev_word", base, 1, 8, 1);
      checkOutput("rev_stopped", stopSeen - stopBase, 1);

      $display("[TB] restart mid-stream");
      applyStimulus(1'b1, 1'b0, 10'd20, 10'd25);
      base = popLog.size();
      waitPops(base + 5, 30);
      applyStimulus(1'b1, 1'b0, 10'd0, 10'd1);
      base = popLog.size();
      repeat (20) @(posedge clk_in);
      #1;
      checkOutput("restart_issue_lat", firstIssueCyc - updCyc, 1);
      checkOutput("restart_valid_lat", firstValidCyc - updCyc, 2 + RL);
      checkOutput("restart_first_word", firstWord, 10'd0);
      checkLoopSeq("restart_seq", base, 4, 0, 2);

      $display("[TB] reset mid-stream");
      @(posedge clk_in);
      #1;
      checkOutput("prerst_tvalid", m_tvalid, 1'b1);
      rst_in = 1'b1;
      #1;
      checkOutput("midrst_tvalid", m_tvalid, 1'b0);
      checkOutput("midrst_running", running, 1'b0);
      checkOutput("midrst_mem_en", mem_en, 1'b0);
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      base = popLog.size();
      repeat (15) @(posedge clk_in);
      #1;
      checkOutput("postrst_no_pop", popLog.size() - base, 0);
      checkOutput("postrst_tvalid", m_tvalid, 1'b0);
      checkOutput("postrst_running", running, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
